score_keeper: RTL and testbench

Game-side producer of the 14-bit binary score consumed by the seven-segment score display. Counts pipe-pass events during play, saturates at the display's four-digit limit, and tracks a session high score. Sits between the game-state/collision logic and the display block, in the single game clock domain.

---
 rtl/score_pkg.sv | 11 +
 rtl/score_keeper_edge_rise.sv | 17 +
 rtl/score_keeper.sv | 86 ++++++++
 tb/tb_score_keeper.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score_keeper block.
package score_pkg;
  localparam int SCORE_W       = 14;
  localparam int MAX_SCORE_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    OVER    = 2'd2
  } state_t;
endpackage

// File: rtl/score_keeper_edge_rise.sv
// Rising-edge detector for the pass level; history is registered, and the
// pulse is formed against it so an event lands on the same edge it is sampled.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 1'b0;
    else     hist <= d;
  end

  assign pulse = d & ~hist;
endmodule

// File: rtl/score_keeper.sv
// Game score counter with saturation and optional session high score.
// Optional feature macro: SCORE_KEEPER_HIGH_SCORE_EN (high score / new_high).
module score_keeper
  import score_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int STEP      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               pass,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               playing
);
  localparam logic [SCORE_W:0] MAX15  = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [SCORE_W:0] STEP15 = (SCORE_W+1)'(STEP);

  state_t             state;
  logic               evt;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_inc;

  edge_rise u_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (pass),
    .pulse (evt)
  );

  // One bit of headroom so score + STEP can never wrap before the clamp.
  assign sum       = {1'b0, score} + STEP15;
  assign score_inc = (sum > MAX15) ? MAX15[SCORE_W-1:0] : sum[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      score <= '0;
    end else begin
      case (state)
        IDLE: if (game_start) begin
          state <= PLAYING;
          score <= '0;
        end
        PLAYING: begin
          if (evt)       score <= score_inc;
          if (game_over) state <= OVER;
        end
        OVER: if (game_start) begin
          state <= PLAYING;
          score <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign playing = (state == PLAYING);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] fin_score;

  // A pass in the game_over cycle is part of the final score.
  assign fin_score = evt ? score_inc : score;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_score <= '0;
      new_high   <= 1'b0;
    end else if (state == PLAYING) begin
      if (game_over && (fin_score > high_score)) begin
        high_score <= fin_score;
        new_high   <= 1'b1;
      end
    end else if (game_start) begin
      new_high <= 1'b0;
    end
  end
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Directed table-driven bench for score_keeper plus saturation sequences.
module tb_score_keeper;
  import score_pkg::*;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, game_start = 1'b0, game_over = 1'b0, pass = 1'b0;
  logic [SCORE_W-1:0] score, high_score, score_s, high_score_s;
  logic new_high, playing, new_high_s, playing_s;

  always #5 clk = ~clk;

  score_keeper u_dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .pass(pass), .score(score), .high_score(high_score),
    .new_high(new_high), .playing(playing)
  );

  score_keeper #(.MAX_SCORE(5), .STEP(2)) u_sat (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .pass(pass), .score(score_s), .high_score(high_score_s),
    .new_high(new_high_s), .playing(playing_s)
  );

  typedef struct {
    logic r, s, o, p;
    int   es;
    logic ep;
    int   eh;
    logic en;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int h(int v);
    return HS ? v : 0;
  endfunction

  function automatic void add(logic r, logic s, logic o, logic p,
                              int es, logic ep, int eh, logic en);
    vec_t v;
    v.r = r; v.s = s; v.o = o; v.p = p;
    v.es = es; v.ep = ep; v.eh = eh; v.en = en;
    tbl.push_back(v);
  endfunction

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then passes in IDLE are ignored
    add(1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      add(0,0,0,1, 0,0,0,0);
      add(0,0,0,0, 0,0,0,0);
    end
    add(0,0,1,0, 0,0,0,0);              // game_over in IDLE ignored
    // game 1: five separated passes
    add(0,1,0,0, 0,1,0,0);
    for (int i = 1; i <= 5; i++) begin
      add(0,0,0,1, i,1,0,0);
      add(0,0,0,0, i,1,0,0);
    end
    add(0,0,1,0, 5,0,h(5),h(1));
    add(0,0,0,1, 5,0,h(5),h(1));         // no counting in OVER
    add(0,0,0,0, 5,0,h(5),h(1));
    // game 2: held pass counts once, start while playing ignored
    add(0,1,0,0, 0,1,h(5),0);
    for (int i = 0; i < 20; i++) add(0,0,0,1, 1,1,h(5),0);
    add(0,1,0,1, 1,1,h(5),0);
    add(0,0,0,0, 1,1,h(5),0);
    for (int i = 2; i <= 7; i++) begin
      add(0,0,0,1, i,1,h(5),0);
      add(0,0,0,0, i,1,h(5),0);
    end
    add(0,0,1,0, 7,0,h(7),h(1));
    // game 3: pass rising with start is not counted; ends at 4
    add(0,1,0,1, 0,1,h(7),0);
    add(0,0,0,1, 0,1,h(7),0);
    add(0,0,0,0, 0,1,h(7),0);
    for (int i = 1; i <= 4; i++) begin
      add(0,0,0,1, i,1,h(7),0);
      add(0,0,0,0, i,1,h(7),0);
    end
    add(0,0,1,0, 4,0,h(7),0);
    // game 4: ties the high score, no new_high
    add(0,1,0,0, 0,1,h(7),0);
    for (int i = 1; i <= 7; i++) begin
      add(0,0,0,1, i,1,h(7),0);
      add(0,0,0,0, i,1,h(7),0);
    end
    add(0,0,1,0, 7,0,h(7),0);
    // fresh session: pass and game_over together at score 2
    add(1,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,1,0,0);
    for (int i = 1; i <= 2; i++) begin
      add(0,0,0,1, i,1,0,0);
      add(0,0,0,0, i,1,0,0);
    end
    add(0,0,1,1, 3,0,h(3),h(1));
    add(0,0,0,0, 3,0,h(3),h(1));
    add(1,0,0,1, 0,0,0,0);              // reset in OVER
    add(0,0,0,0, 0,0,0,0);
    // reset mid-game overrides start and pass
    add(0,1,0,0, 0,1,0,0);
    add(0,0,0,1, 1,1,0,0);
    add(0,0,0,0, 1,1,0,0);
    add(1,1,1,1, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; game_start = tbl[i].s;
      game_over = tbl[i].o; pass = tbl[i].p;
      cyc();
      check($sformatf("v%0d score", i),      score,      tbl[i].es);
      check($sformatf("v%0d playing", i),    playing,    tbl[i].ep);
      check($sformatf("v%0d high_score", i), high_score, tbl[i].eh);
      check($sformatf("v%0d new_high", i),   new_high,   tbl[i].en);
    end

    // saturation: MAX=5/STEP=2 instance and the default 9999 instance
    rst = 1'b1; game_start = 1'b0; game_over = 1'b0; pass = 1'b0;
    cyc();
    rst = 1'b0; game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pass = 1'b1; cyc();
      pass = 1'b0; cyc();
      check($sformatf("sat5 ev%0d", k), score_s, (k == 1) ? 2 : (k == 2) ? 4 : 5);
      check($sformatf("main ev%0d", k), score, k);
    end
    for (int k = 5; k <= 10001; k++) begin
      pass = 1'b1; cyc();
      pass = 1'b0; cyc();
      if (k == 9998) check("main 9998", score, 9998);
    end
    check("main sat 9999", score, 9999);
    game_over = 1'b1; cyc(); game_over = 1'b0;
    check("main over playing", playing, 0);
    check("main hs 9999", high_score, h(9999));
    check("main nh", new_high, h(1));
    check("sat hs 5", high_score_s, h(5));
    check("sat score 5", score_s, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
